// File: rtl/hex_token_parser.sv
// Streaming ASCII hex token parser: digits accumulate, separator/invalid emits.
// Optional macro HEXPARSE_LOWERCASE_EN accepts a-f as digits.
module hex_token_parser #(
   parameter  int DIGITS = 8,
   localparam int W      = 4 * DIGITS,
   localparam int CW     = $clog2(DIGITS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    in_char,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [W-1:0]  out_word,
   output logic [CW-1:0] out_count,
   output logic          out_overflow,
   output logic          out_badchar,
   output logic          out_valid,
   input  logic          out_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_acc;
   logic [CW-1:0] r_cnt;
   logic          r_ovf;
   logic          r_bad;

   logic          w_dig;
   logic          w_sep;
   logic [3:0]    w_nib;
   logic [W-1:0]  w_shift;

   always_comb begin
      w_dig = 1'b0;
      w_nib = 4'd0;
      if (in_char >= 8'h30 && in_char <= 8'h39) begin
         w_dig = 1'b1;
         w_nib = 4'(in_char - 8'h30);
      end else if (in_char >= 8'h41 && in_char <= 8'h46) begin
         w_dig = 1'b1;
         w_nib = 4'(in_char - 8'h37);
      end
`ifdef HEXPARSE_LOWERCASE_EN
      else if (in_char >= 8'h61 && in_char <= 8'h66) begin
         w_dig = 1'b1;
         w_nib = 4'(in_char - 8'h57);
      end
`endif
   end

   assign w_sep = (in_char == 8'h20) || (in_char == 8'h0D) ||
                  (in_char == 8'h0A) || (in_char == 8'h2C);

   // A single-digit word simply takes the newest nibble
   generate
      if (DIGITS == 1) begin : g_one
         assign w_shift = w_nib;
      end else begin : g_many
         assign w_shift = {r_acc[W-5:0], w_nib};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_bad   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (w_dig) begin
                     r_acc   <= W'(w_nib);
                     r_cnt   <= CW'(1);
                     r_ovf   <= 1'b0;
                     r_state <= ACCUM;
                  end else if (!w_sep) begin
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_bad   <= 1'b1;
                     r_state <= EMIT;
                  end
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  if (w_dig) begin
                     r_acc <= w_shift;
                     if (r_cnt == CW'(DIGITS)) r_ovf <= 1'b1;
                     else                      r_cnt <= r_cnt + CW'(1);
                  end else begin
                     r_bad   <= !w_sep;
                     r_state <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
                  r_bad   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready     = (r_state != EMIT);
   assign out_valid    = (r_state == EMIT);
   assign out_word     = r_acc;
   assign out_count    = r_cnt;
   assign out_overflow = r_ovf;
   assign out_badchar  = r_bad;

endmodule

// File: tb/tb_hex_token_parser.sv
// Scoreboard bench for hex_token_parser: DIGITS=8 and DIGITS=4 instances.
// Expected results are queued at stimulus time and popped by monitors.
module tb_hex_token_parser;

   logic        clk;
   logic        rst;

   logic [7:0]  c8, c4;
   logic        v8, v4;
   logic        rdy8, rdy4;
   logic        or8, or4;
   logic        ov8, ov4;
   logic [31:0] w8;
   logic [15:0] w4;
   logic [3:0]  n8;
   logic [2:0]  n4;
   logic        f8, f4;
   logic        b8, b4;

   typedef struct {
      logic [31:0] word;
      int          cnt;
      logic        ovf;
      logic        bad;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];

   int checks   = 0;
   int failures = 0;
   int waits    = 0;

   hex_token_parser #(.DIGITS(8)) u8 (
      .clk(clk), .rst(rst), .in_char(c8), .in_valid(v8),
      .in_ready(rdy8), .out_word(w8), .out_count(n8),
      .out_overflow(f8), .out_badchar(b8), .out_valid(ov8),
      .out_ready(or8)
   );

   hex_token_parser #(.DIGITS(4)) u4 (
      .clk(clk), .rst(rst), .in_char(c4), .in_valid(v4),
      .in_ready(rdy4), .out_word(w4), .out_count(n4),
      .out_overflow(f4), .out_badchar(b4), .out_valid(ov4),
      .out_ready(or4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && ov8 && or8) begin
         exp_t e;
         checks++;
         if (q8.size() == 0) begin
            failures++;
            $display("FAIL res8 unexpected word=%h cnt=%0d", w8, n8);
         end else begin
            e = q8.pop_front();
            if (w8 !== e.word || int'(n8) != e.cnt ||
                f8 !== e.ovf || b8 !== e.bad) begin
               failures++;
               $display("FAIL res8 got w=%h c=%0d o=%b b=%b want w=%h c=%0d o=%b b=%b",
                        w8, n8, f8, b8, e.word, e.cnt, e.ovf, e.bad);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov4 && or4) begin
         exp_t e;
         checks++;
         if (q4.size() == 0) begin
            failures++;
            $display("FAIL res4 unexpected word=%h cnt=%0d", w4, n4);
         end else begin
            e = q4.pop_front();
            if ({16'h0, w4} !== e.word || int'(n4) != e.cnt ||
                f4 !== e.ovf || b4 !== e.bad) begin
               failures++;
               $display("FAIL res4 got w=%h c=%0d o=%b b=%b want w=%h c=%0d o=%b b=%b",
                        w4, n4, f4, b4, e.word, e.cnt, e.ovf, e.bad);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic push(input int s, input logic [31:0] w, input int c,
                       input logic o, input logic b);
      exp_t e;
      e.word = w;
      e.cnt  = c;
      e.ovf  = o;
      e.bad  = b;
      if (s == 0) q8.push_back(e);
      else        q4.push_back(e);
   endtask

   // Present a byte and hold it until the parser takes it
   task automatic send(input int s, input logic [7:0] ch);
      int n;
      n = 0;
      if (s == 0) begin c8 = ch; v8 = 1'b1; end
      else        begin c4 = ch; v4 = 1'b1; end
      forever begin
         @(negedge clk);
         if ((s == 0) ? rdy8 : rdy4) break;
         n++;
         waits++;
         if (n > 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout sel=%0d ch=%h", s, ch);
            break;
         end
      end
      @(posedge clk);
      #1;
      if (s == 0) v8 = 1'b0;
      else        v4 = 1'b0;
   endtask

   task automatic send_str(input int s, input string str);
      for (int i = 0; i < str.len(); i++) send(s, str[i]);
   endtask

   initial begin
      rst = 1'b1;
      c8 = 8'h0; c4 = 8'h0;
      v8 = 1'b0; v4 = 1'b0;
      or8 = 1'b1; or4 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'h0, ov8}, 32'h0);
      chk("rst_ready", {31'h0, rdy8}, 32'h1);
      chk("rst_word", w8, 32'h0);
      chk("rst_flags", {26'h0, n8, f8, b8}, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      push(0, 32'h00001A2B, 4, 1'b0, 1'b0);
      send_str(0, "1A2B");
      send(0, 8'h0A);
      @(negedge clk);
      chk("latency_valid", {31'h0, ov8}, 32'h1);
      @(posedge clk);
      #1;

      waits = 0;
      push(1, 32'h3456, 4, 1'b1, 1'b0);
      send_str(1, "12345");
      send(1, "6");
      chk("ovf_no_stall", waits, 0);
      send(1, " ");
      push(1, 32'hFFFF, 4, 1'b0, 1'b0);
      send_str(1, "FFFF,");

      push(0, 32'h12345678, 8, 1'b0, 1'b0);
      send_str(0, "12345678 ");
      push(0, 32'h23456789, 8, 1'b1, 1'b0);
      send_str(0, "123456789 ");

      push(0, 32'h7, 1, 1'b0, 1'b1);
      send_str(0, "  ,");
      send(0, 8'h0D);
      send_str(0, "7G");
      push(0, 32'h0, 0, 1'b0, 1'b1);
      send(0, "Z");

`ifdef HEXPARSE_LOWERCASE_EN
      push(0, 32'hFF, 2, 1'b0, 1'b0);
`else
      push(0, 32'h0, 0, 1'b0, 1'b1);
      push(0, 32'h0, 0, 1'b0, 1'b1);
`endif
      send_str(0, "ff ");

      @(posedge clk);
      #1;
      or8 = 1'b0;
      push(0, 32'hAB, 2, 1'b0, 1'b0);
      send_str(0, "AB ");
      c8 = "C";
      v8 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_ready", {31'h0, rdy8}, 32'h0);
         chk("stall_hold", {ov8, n8, f8, b8, w8[23:0]},
             {1'b1, 4'd2, 1'b0, 1'b0, 24'h0000AB});
      end
      @(posedge clk);
      #1;
      or8 = 1'b1;
      push(0, 32'hCD, 2, 1'b0, 1'b0);
      send_str(0, "CD ");

      send_str(0, "12");
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", {ov8, n8, f8, b8, w8[26:0]}, 32'h0);
      chk("mid_rst_ready", {31'h0, rdy8}, 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      push(0, 32'h3, 1, 1'b0, 1'b0);
      send_str(0, "3 ");

      for (int t = 0; t < 100; t++) begin
         if (q8.size() == 0 && q4.size() == 0) break;
         @(posedge clk);
      end
      repeat (3) @(posedge clk);
      chk("drain8", q8.size(), 0);
      chk("drain4", q4.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
